// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared state encoding and width helper for the round-robin stream arbiter
package axis_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating priority encoder, scans last_i+1, last_i+2, ... modulo N
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int ID_W = clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] last_i,
  output logic            found_o,
  output logic [ID_W-1:0] index_o
);

  // Walk from the farthest offset down so the nearest requester after last_i wins.
  always_comb begin
    logic [ID_W-1:0] cand;
    found_o = 1'b0;
    index_o = '0;
    cand    = '0;
    for (int off = N; off >= 1; off--) begin
      cand = ID_W'((int'(last_i) + off) % N);
      if (req_i[cand]) begin
        found_o = 1'b1;
        index_o = cand;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - round-robin stream arbiter that locks onto one source per packet or capped burst
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int DATA_W    = 4,
  parameter int MAX_BEATS = 0,
  localparam int ID_W     = clog2(N)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N-1:0]        s_tvalid_i,
  output logic [N-1:0]        s_tready_o,
  input  logic [N*DATA_W-1:0] s_tdata_i,
  input  logic [N-1:0]        s_tlast_i,
  output logic                m_tvalid_o,
  input  logic                m_tready_i,
  output logic [DATA_W-1:0]   m_tdata_o,
  output logic                m_tlast_o,
  output logic [ID_W-1:0]     m_tid_o,
  output logic                busy_o
);

  localparam int CNT_W = (MAX_BEATS > 1) ? clog2(MAX_BEATS) : 1;

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic [DATA_W-1:0] src_data [N];
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              hs;
  logic              cap_hit;

  rr_pick #(
    .N(N)
  ) u_pick (
    .req_i  (s_tvalid_i),
    .last_i (last_q),
    .found_o(pick_found),
    .index_o(pick_idx)
  );

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign src_data[k] = s_tdata_i[k*DATA_W +: DATA_W];
  end

  assign sel_valid = s_tvalid_i[grant_q];
  assign sel_last  = s_tlast_i[grant_q];
  assign sel_data  = src_data[grant_q];
  assign hs        = (state_q == ST_LOCKED) && sel_valid && m_tready_i;
  assign cap_hit   = (MAX_BEATS != 0) && (cnt_q == CNT_W'(MAX_BEATS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // tlast and the burst cap landing on one beat collapse into a single release.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (pick_found) begin
        grant_d = pick_idx;
        last_d  = pick_idx;
        cnt_d   = '0;
        state_d = ST_LOCKED;
      end
    end else if (hs) begin
      if (sel_last || cap_hit) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    m_tvalid_o = 1'b0;
    m_tdata_o  = '0;
    m_tlast_o  = 1'b0;
    s_tready_o = '0;
    busy_o     = 1'b0;
    m_tid_o    = grant_q;
    if (state_q == ST_LOCKED) begin
      busy_o              = 1'b1;
      m_tvalid_o          = sel_valid;
      m_tdata_o           = sel_data;
      m_tlast_o           = sel_last;
      s_tready_o[grant_q] = m_tready_i;
    end
  end

endmodule
